// File: rtl/idct_transpose4_if.sv
// rtl/idct_transpose4_if.sv - stream handshake bundle for the 4x4 IDCT transpose buffer
interface idct_transpose4_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [24:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [24:0] out_1;
  logic signed [24:0] out_2;
  logic signed [24:0] out_3;
  logic signed [24:0] out_4;
  logic [1:0]        out_col;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_1, out_2, out_3, out_4, out_col
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_1, out_2, out_3, out_4, out_col
  );
endinterface

// File: rtl/idct_transpose4.sv
// rtl/idct_transpose4.sv - ping-pong 4x4 transpose buffer between IDCT passes
// Rows arrive serially, columns leave four lanes wide; two banks overlap fill and drain.
module idct_transpose4 #(
  parameter bit CLIP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  idct_transpose4_if.slave io_bus
);

  logic signed [24:0] r_mem [2][4][4];
  logic [1:0]         r_full;
  logic               r_wr_bank;
  logic [3:0]         r_wr_idx;
  logic               r_rd_bank;
  logic [1:0]         r_rd_col;

  logic               w_wr_fire;
  logic               w_rd_fire;
  logic signed [24:0] w_clip;

  assign io_bus.in_ready  = !r_full[r_wr_bank];
  assign io_bus.out_valid = r_full[r_rd_bank];
  assign io_bus.out_col   = r_rd_col;
  assign io_bus.out_1     = r_mem[r_rd_bank][0][r_rd_col];
  assign io_bus.out_2     = r_mem[r_rd_bank][1][r_rd_col];
  assign io_bus.out_3     = r_mem[r_rd_bank][2][r_rd_col];
  assign io_bus.out_4     = r_mem[r_rd_bank][3][r_rd_col];

  assign w_wr_fire = io_bus.in_valid && !r_full[r_wr_bank];
  assign w_rd_fire = r_full[r_rd_bank] && io_bus.out_ready;

  // Saturate to the 16-bit intermediate range, kept sign-extended at 25 bits.
  always_comb begin
    w_clip = io_bus.in_data;
    if (CLIP) begin
      if (io_bus.in_data > 25'sd32767) begin
        w_clip = 25'sd32767;
      end else if (io_bus.in_data < -25'sd32768) begin
        w_clip = -25'sd32768;
      end
    end
  end

  // Write and read always hit different banks, so both full-flag updates may land together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_idx  <= 4'd0;
      r_rd_bank <= 1'b0;
      r_rd_col  <= 2'd0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            r_mem[b][r][c] <= 25'sd0;
          end
        end
      end
    end else begin
      if (w_wr_fire) begin
        r_mem[r_wr_bank][r_wr_idx[3:2]][r_wr_idx[1:0]] <= w_clip;
        r_wr_idx <= r_wr_idx + 4'd1;
        if (r_wr_idx == 4'd15) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= !r_wr_bank;
        end
      end
      if (w_rd_fire) begin
        r_rd_col <= r_rd_col + 2'd1;
        if (r_rd_col == 2'd3) begin
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank         <= !r_rd_bank;
        end
      end
    end
  end

endmodule
